// File: rtl/pwr_seq_pkg.sv
// Shared state codes, mode encodings and helpers for the power-mode sequencer.
package pwr_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StOn   = 4'd0;
  localparam state_t StOff  = 4'd1;
  localparam state_t StIso  = 4'd2;
  localparam state_t StRet  = 4'd3;
  localparam state_t StPdn  = 4'd4;
  localparam state_t StPup  = 4'd5;
  localparam state_t StRstr = 4'd6;
  localparam state_t StDiso = 4'd7;
  localparam state_t StLvl  = 4'd8;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'd0;
  localparam mode_t MODE_LOW  = 2'd1;
  localparam mode_t MODE_MOD  = 2'd2;
  localparam mode_t MODE_HIGH = 2'd3;

  // Bit 0 = low rail, bit 1 = moderate rail, bit 2 = high rail.
  function automatic logic [2:0] mode_rails(input mode_t mode);
    logic [2:0] rails;
    case (mode)
      MODE_LOW:  rails = 3'b001;
      MODE_MOD:  rails = 3'b010;
      MODE_HIGH: rails = 3'b100;
      default:   rails = 3'b000;
    endcase
    return rails;
  endfunction

  function automatic logic is_stable(input state_t state);
    return (state == StOn) || (state == StOff);
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter that saturates at zero; zero_o flags the end of a step.
module pwr_seq_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-mode sequencer: FSM walking isolate/retain/power steps, with every output
// registered as a decode of the current state.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned STEP_CYC   = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  output logic [1:0] cur_mode,
  output logic       done,
  output logic       IN_PWR,
  output logic       OUT_PWR,
  output logic       ALU_PWR_low,
  output logic       ALU_PWR_moderate,
  output logic       ALU_PWR_high,
  output logic       IN_ISO_PWR,
  output logic       OUT_RET_PWR,
  output logic       IN_ISO,
  output logic       OUT_RET
);

  localparam int unsigned MaxCyc = (STEP_CYC > SETTLE_CYC) ? STEP_CYC : SETTLE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam logic [CntW-1:0] StepLd   = CntW'(STEP_CYC - 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE_CYC - 1);

  state_t state_q, state_d;
  mode_t  tgt_q, tgt_d;
  logic   ld;
  logic [CntW-1:0] ld_val;
  logic   tmr_zero;
  logic   accept;

  logic       in_pwr_q, in_pwr_d;
  logic       out_pwr_q, out_pwr_d;
  logic [2:0] alu_q, alu_d;
  logic       iso_q, iso_d;
  logic       ret_q, ret_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  mode_t      cur_mode_q, cur_mode_d;
  logic       aon_q;

  pwr_seq_timer #(
    .Width(CntW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (tmr_zero)
  );

  // ready_q lags state_q by one edge, so both must agree before a request is taken.
  assign accept = req_valid && ready_q && is_stable(state_q) && (req_mode != cur_mode_q);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      StOn: begin
        if (accept) begin
          tgt_d = req_mode;
          ld    = 1'b1;
          if (req_mode == MODE_OFF) begin
            state_d = StIso;
            ld_val  = StepLd;
          end else begin
            state_d = StLvl;
            ld_val  = SettleLd;
          end
        end
      end
      StOff: begin
        if (accept) begin
          tgt_d   = req_mode;
          state_d = StPup;
          ld      = 1'b1;
          ld_val  = SettleLd;
        end
      end
      StIso:  if (tmr_zero) begin state_d = StRet;  ld = 1'b1; ld_val = StepLd; end
      StRet:  if (tmr_zero) begin state_d = StPdn;  ld = 1'b1; ld_val = StepLd; end
      StPdn:  if (tmr_zero) begin state_d = StOff;  ld = 1'b1; end
      StPup:  if (tmr_zero) begin state_d = StRstr; ld = 1'b1; ld_val = StepLd; end
      StRstr: if (tmr_zero) begin state_d = StDiso; ld = 1'b1; ld_val = StepLd; end
      StDiso: if (tmr_zero) begin state_d = StOn;   ld = 1'b1; end
      StLvl:  if (tmr_zero) begin state_d = StOn;   ld = 1'b1; end
      default: begin
        state_d = StOn;
        tgt_d   = MODE_HIGH;
      end
    endcase
  end

  // Isolation and retention steps keep the rails as they were on entry.
  always_comb begin
    in_pwr_d   = in_pwr_q;
    out_pwr_d  = out_pwr_q;
    alu_d      = alu_q;
    iso_d      = iso_q;
    ret_d      = ret_q;
    cur_mode_d = cur_mode_q;
    unique case (state_q)
      StOn: begin
        in_pwr_d   = 1'b1;
        out_pwr_d  = 1'b1;
        alu_d      = mode_rails(tgt_q);
        iso_d      = 1'b0;
        ret_d      = 1'b0;
        cur_mode_d = tgt_q;
      end
      StOff: begin
        in_pwr_d   = 1'b0;
        out_pwr_d  = 1'b0;
        alu_d      = 3'b000;
        iso_d      = 1'b1;
        ret_d      = 1'b1;
        cur_mode_d = MODE_OFF;
      end
      StIso: iso_d = 1'b1;
      StRet: begin
        iso_d = 1'b1;
        ret_d = 1'b1;
      end
      StPdn: begin
        in_pwr_d  = 1'b0;
        out_pwr_d = 1'b0;
        alu_d     = 3'b000;
        iso_d     = 1'b1;
        ret_d     = 1'b1;
      end
      StPup: begin
        in_pwr_d  = 1'b1;
        out_pwr_d = 1'b1;
        alu_d     = mode_rails(tgt_q);
        iso_d     = 1'b1;
        ret_d     = 1'b1;
      end
      StRstr: ret_d = 1'b0;
      StDiso: iso_d = 1'b0;
      StLvl:  alu_d = mode_rails(tgt_q);
      default: ;
    endcase
    ready_d = is_stable(state_q);
    done_d  = is_stable(state_q) && !ready_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StOn;
      tgt_q      <= MODE_HIGH;
      in_pwr_q   <= 1'b1;
      out_pwr_q  <= 1'b1;
      alu_q      <= mode_rails(MODE_HIGH);
      iso_q      <= 1'b0;
      ret_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      cur_mode_q <= MODE_HIGH;
      aon_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      in_pwr_q   <= in_pwr_d;
      out_pwr_q  <= out_pwr_d;
      alu_q      <= alu_d;
      iso_q      <= iso_d;
      ret_q      <= ret_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      cur_mode_q <= cur_mode_d;
      aon_q      <= 1'b1;
    end
  end

  assign req_ready        = ready_q;
  assign cur_mode         = cur_mode_q;
  assign done             = done_q;
  assign IN_PWR           = in_pwr_q;
  assign OUT_PWR          = out_pwr_q;
  assign ALU_PWR_low      = alu_q[0];
  assign ALU_PWR_moderate = alu_q[1];
  assign ALU_PWR_high     = alu_q[2];
  assign IN_ISO_PWR       = aon_q;
  assign OUT_RET_PWR      = aon_q;
  assign IN_ISO           = iso_q;
  assign OUT_RET          = ret_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Bench for pwr_seq_ctrl: timeline model checked every cycle plus literal spot checks.
module tb_pwr_seq_ctrl;

  localparam int unsigned Step   = 2;
  localparam int unsigned Settle = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready, done;
  logic [1:0] cur_mode;
  logic       IN_PWR, OUT_PWR, ALU_PWR_low, ALU_PWR_moderate, ALU_PWR_high;
  logic       IN_ISO_PWR, OUT_RET_PWR, IN_ISO, OUT_RET;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc     = 0;

  pwr_seq_ctrl #(
    .STEP_CYC   (Step),
    .SETTLE_CYC (Settle)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_mode         (req_mode),
    .req_ready        (req_ready),
    .cur_mode         (cur_mode),
    .done             (done),
    .IN_PWR           (IN_PWR),
    .OUT_PWR          (OUT_PWR),
    .ALU_PWR_low      (ALU_PWR_low),
    .ALU_PWR_moderate (ALU_PWR_moderate),
    .ALU_PWR_high     (ALU_PWR_high),
    .IN_ISO_PWR       (IN_ISO_PWR),
    .OUT_RET_PWR      (OUT_RET_PWR),
    .IN_ISO           (IN_ISO),
    .OUT_RET          (OUT_RET)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // {IN_PWR, OUT_PWR, low, moderate, high} for a stable mode.
  function automatic logic [4:0] rails_of(input logic [1:0] m);
    return {m != 2'd0, m != 2'd0, m == 2'd1, m == 2'd2, m == 2'd3};
  endfunction

  function automatic logic [4:0] dut_rails();
    return {IN_PWR, OUT_PWR, ALU_PWR_low, ALU_PWR_moderate, ALU_PWR_high};
  endfunction

  // Model: a sequence is just "k edges since accept" against the published timeline.
  bit         m_on = 1'b0;
  bit         m_busy = 1'b0;
  bit         m_done;
  int         m_k, m_len;
  logic [1:0] m_mode, m_new;

  initial begin
    logic [4:0]  e_rails;
    logic        e_iso, e_ret, e_ready;
    logic [15:0] e_vec, a_vec;
    forever begin
      @(posedge clk);
      #2;
      m_done = 1'b0;
      if (!reset) begin
        m_on   = 1'b1;
        m_busy = 1'b0;
        m_mode = 2'd3;
      end else if (m_on) begin
        if (m_busy) begin
          m_k++;
          if (m_k == m_len) begin
            m_busy = 1'b0;
            m_mode = m_new;
            m_done = 1'b1;
          end
        end else if (req_valid && req_mode != m_mode) begin
          m_busy = 1'b1;
          m_k    = 0;
          m_new  = req_mode;
          if (m_mode == 2'd0)      m_len = 1 + Settle + 2 * Step;
          else if (req_mode == 0)  m_len = 1 + 3 * Step;
          else                     m_len = 1 + Settle;
        end
      end
      if (m_on) begin
        e_ready = !m_busy || (m_k == 0);
        e_rails = rails_of(m_mode);
        e_iso   = (m_mode == 2'd0);
        e_ret   = (m_mode == 2'd0);
        if (m_busy && m_k >= 1) begin
          if (m_new == 2'd0) begin
            e_iso = 1'b1;
            e_ret = (m_k >= 1 + Step);
            if (m_k >= 1 + 2 * Step) e_rails = 5'b00000;
          end else if (m_mode == 2'd0) begin
            e_rails = rails_of(m_new);
            e_ret   = (m_k < 1 + Settle);
            e_iso   = (m_k < 1 + Settle + Step);
          end else begin
            e_rails = rails_of(m_new);
          end
        end
        e_vec = {3'b000, e_ready, m_mode, m_done, e_rails, 2'b11, e_iso, e_ret};
        a_vec = {3'b000, req_ready, cur_mode, done, dut_rails(), IN_ISO_PWR, OUT_RET_PWR,
                 IN_ISO, OUT_RET};
        check("model_outputs", a_vec, e_vec);
        check("inv_alu_onehot",
              16'($countones({ALU_PWR_low, ALU_PWR_moderate, ALU_PWR_high}) <= 1), 16'd1);
        check("inv_iso_when_in_off", 16'(IN_PWR | IN_ISO), 16'd1);
        check("inv_ret_when_out_off", 16'(OUT_PWR | OUT_RET), 16'd1);
      end
    end
  end

  task automatic do_req(input logic [1:0] m);
    @(negedge clk);
    req_valid = 1'b1;
    req_mode  = m;
    @(posedge clk);
    #1;
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Return 3 time units after edge acc+k.
  task automatic at(input int k);
    while (cyc < acc + k) begin
      @(posedge clk);
      #1;
    end
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rails"}, 16'(dut_rails()), 16'(5'b11001));
    check({tag, "_ctl"}, 16'({IN_ISO, OUT_RET, req_ready, cur_mode, done}), 16'(6'b001110));
    check({tag, "_aon"}, 16'({IN_ISO_PWR, OUT_RET_PWR}), 16'(2'b11));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #3;
    check_reset_state("reset");

    // Power-down from HIGH.
    do_req(2'd0);
    at(1); check("pd_iso_a1", 16'({IN_ISO, OUT_RET, req_ready}), 16'(3'b100));
    at(3); check("pd_ret_a3", 16'({OUT_RET, IN_PWR}), 16'(2'b11));
    at(5); check("pd_rails_a5", 16'(dut_rails()), 16'd0);
    at(6); check("pd_done_a6", 16'({done, req_ready}), 16'd0);
    at(7); check("pd_off_a7", 16'({done, req_ready, cur_mode}), 16'(4'b1100));
    at(8); check("pd_done_a8", 16'(done), 16'd0);

    // Power-up to MOD.
    do_req(2'd2);
    at(1); check("pu_rails_a1", 16'({dut_rails(), OUT_RET, IN_ISO}), 16'(7'b1101011));
    at(4); check("pu_ret_a4", 16'(OUT_RET), 16'd1);
    at(5); check("pu_ret_a5", 16'({OUT_RET, IN_ISO}), 16'(2'b01));
    at(7); check("pu_iso_a7", 16'(IN_ISO), 16'd0);
    at(8); check("pu_done_a8", 16'(done), 16'd0);
    at(9); check("pu_done_a9", 16'({done, cur_mode, req_ready}), 16'(4'b1101));

    // Level changes: MOD -> HIGH -> LOW, then LOW again as a no-op.
    do_req(2'd3);
    at(1); check("lvl_high_a1", 16'(dut_rails()), 16'(5'b11001));
    at(5); check("lvl_high_a5", 16'({done, cur_mode}), 16'(3'b111));
    do_req(2'd1);
    at(1); check("lvl_low_a1", 16'({dut_rails(), IN_ISO, OUT_RET}), 16'(7'b1110000));
    at(4); check("lvl_low_a4", 16'({done, req_ready, cur_mode}), 16'(4'b0011));
    at(5); check("lvl_low_a5", 16'({done, cur_mode}), 16'(3'b101));
    do_req(2'd1);
    at(1); check("noop_a1", 16'({req_ready, done, cur_mode}), 16'(4'b1001));
    at(5); check("noop_a5", 16'({done, dut_rails()}), 16'(6'b011100));

    // Power-down from LOW with requests hammered while busy.
    do_req(2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i != 2);
      req_mode  = 2'(i + 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    at(7); check("busy_final", 16'({done, cur_mode, dut_rails()}), 16'(8'b10000000));

    do_req(2'd3);
    at(9); check("pu_high_a9", 16'({done, cur_mode, dut_rails()}), 16'(8'b11111001));

    // Reset in the middle of a power-down, then a clean power-down.
    do_req(2'd0);
    at(3); check("mid_ret_a3", 16'(OUT_RET), 16'd1);
    @(negedge clk);
    reset = 1'b0;
    at(4);
    check_reset_state("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    do_req(2'd0);
    at(7); check("post_rst_pd_a7", 16'({done, cur_mode, dut_rails()}), 16'(8'b10000000));

    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
